alu_seq: RTL and testbench

//  Parametrised multi-cycle ALU for the multi-cycle/pipelined datapath; successor of the single-cycle ALU.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_muldiv_iter.sv | 71 +++++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 tb/tb_alu_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encoding for the sequential ALU.
// Imported by alu_seq and alu_muldiv_iter.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// Ports: clk, rst_n, start_i, div_i, a_i, b_i in; last_o, hi_o, lo_o (post-step values) out.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q, busy_q;

  logic [WIDTH:0]   x, y, acc;
  logic [WIDTH+1:0] sum;

  // One adder shared: hi+A for multiply, {rem,q_msb}-B for divide.
  always_comb begin
    x   = div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
    y   = div_q ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    sum = {1'b0, x} + {1'b0, y} + (WIDTH+2)'(div_q);
    acc = lo_q[0] ? sum[WIDTH:0] : {1'b0, hi_q};
    hi_d = acc[WIDTH:1];
    lo_d = {acc[0], lo_q[WIDTH-1:1]};
    if (div_q) begin
      // Top carry set means the partial remainder covered the divisor.
      hi_d = sum[WIDTH+1] ? sum[WIDTH-1:0] : x[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], sum[WIDTH+1]};
    end
  end

  assign last_o = busy_q && (cnt_q == CNT_W'(WIDTH-1));
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      hi_q   <= '0;
      lo_q   <= div_i ? a_i : b_i;
      opnd_q <= div_i ? b_i : a_i;
      cnt_q  <= '0;
      div_q  <= div_i;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready in and out; iterative MULTU/DIVU under ALU_MULDIV_EN.
// Ports: clk, rst_n, in_valid/in_ready, alu_ctr, alu_src, read_1, read_2, imm_ext,
//        out_valid/out_ready, result, result_hi, zero, ovf, err.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctr,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] read_1,
  input  logic [WIDTH-1:0] read_2,
  input  logic [WIDTH-1:0] imm_ext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0]   b_sel, b_neg, sum, dif;
  logic [SHAMT_W-1:0] shamt;

`ifdef ALU_MULDIV_EN
  logic             it_start, it_last;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic             divz_q, divz_d;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (it_start),
    .div_i   (alu_ctr == OP_DIVU),
    .a_i     (read_1),
    .b_i     (b_sel),
    .last_o  (it_last),
    .hi_o    (it_hi),
    .lo_o    (it_lo)
  );
`endif

  assign b_sel = alu_src ? imm_ext : read_2;
  assign b_neg = ~b_sel + WIDTH'(1);
  assign sum   = read_1 + b_sel;
  assign dif   = read_1 - b_sel;
  assign shamt = b_sel[SHAMT_W-1:0];

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef ALU_MULDIV_EN
    it_start = 1'b0;
    divz_d   = divz_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          res_d   = '0;
          hi_d    = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          case (alu_ctr)
            OP_ADD: begin
              res_d = sum;
              ovf_d = (read_1[WIDTH-1] == b_sel[WIDTH-1]) &&
                      (sum[WIDTH-1] != read_1[WIDTH-1]);
            end
            OP_SUB: begin
              res_d = dif;
              ovf_d = (read_1[WIDTH-1] == b_neg[WIDTH-1]) &&
                      (dif[WIDTH-1] != read_1[WIDTH-1]);
            end
            OP_AND:  res_d = read_1 & b_sel;
            OP_OR:   res_d = read_1 | b_sel;
            OP_XOR:  res_d = read_1 ^ b_sel;
            OP_NOR:  res_d = ~(read_1 | b_sel);
            OP_SLT:
              res_d = WIDTH'($signed(read_1) < $signed(b_sel));
            OP_SLTU: res_d = WIDTH'(read_1 < b_sel);
            OP_SLL:  res_d = read_1 << shamt;
            OP_SRL:  res_d = read_1 >> shamt;
            OP_SRA:  res_d = $unsigned($signed(read_1) >>> shamt);
            OP_MULTU, OP_DIVU: begin
`ifdef ALU_MULDIV_EN
              it_start = 1'b1;
              divz_d   = (alu_ctr == OP_DIVU) && (b_sel == '0);
              state_d  = S_BUSY;
`else
              err_d = 1'b1;
`endif
            end
            default: res_d = '0;
          endcase
          zero_d = (res_d == '0);
        end
      end
      S_BUSY: begin
`ifdef ALU_MULDIV_EN
        if (it_last) begin
          res_d   = it_lo;
          hi_d    = it_hi;
          zero_d  = (it_lo == '0);
          err_d   = divz_q;
          state_d = S_DONE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

`ifdef ALU_MULDIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) divz_q <= 1'b0;
    else        divz_q <= divz_d;
  end
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign result_hi = hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus random ops vs a model.
// Expectations for MULTU/DIVU follow ALU_MULDIV_EN.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctr = '0;
  logic        alu_src = 1'b0;
  logic [31:0] read_1 = '0, read_2 = '0, imm_ext = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result, result_hi;
  logic        zero, ovf, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctr(alu_ctr), .alu_src(alu_src),
    .read_1(read_1), .read_2(read_2), .imm_ext(imm_ext),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .zero(zero), .ovf(ovf), .err(err)
  );

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        z;
    logic        o;
    logic        e;
    logic [7:0]  lat;
  } res_t;

  typedef struct packed {
    logic [3:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] r2;
    logic [31:0] imm;
    res_t        exp;
  } vec_t;

  localparam bit MD = `ifdef ALU_MULDIV_EN 1'b1 `else 1'b0 `endif ;

  // Reference: plain arithmetic on the selected operands.
  function automatic res_t model(input logic [3:0] op, input logic src,
                                 input logic [31:0] a, r2, imm);
    res_t r;
    logic [31:0] b, nb;
    logic [63:0] p;
    int sh;
    b = src ? imm : r2;
    sh = int'(b % 32);
    r = '0;
    r.lat = 8'd1;
    case (op)
      OP_ADD: begin
        r.lo = a + b;
        r.o = (a[31] == b[31]) && (r.lo[31] != a[31]);
      end
      OP_SUB: begin
        nb = 32'd0 - b;
        r.lo = a - b;
        r.o = (a[31] == nb[31]) && (r.lo[31] != a[31]);
      end
      OP_AND:  r.lo = a & b;
      OP_OR:   r.lo = a | b;
      OP_XOR:  r.lo = a ^ b;
      OP_NOR:  r.lo = ~(a | b);
      OP_SLT:  r.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r.lo = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r.lo = a << sh;
      OP_SRL:  r.lo = a >> sh;
      OP_SRA:  r.lo = 32'($signed(a) >>> sh);
      OP_MULTU: begin
        if (MD) begin
          p = {32'd0, a} * {32'd0, b};
          r.lo = p[31:0];
          r.hi = p[63:32];
          r.lat = 8'd33;
        end else r.e = 1'b1;
      end
      OP_DIVU: begin
        if (MD) begin
          r.lat = 8'd33;
          if (b == 0) begin
            r.lo = 32'hFFFF_FFFF;
            r.hi = a;
            r.e = 1'b1;
          end else begin
            r.lo = a / b;
            r.hi = a % b;
          end
        end else r.e = 1'b1;
      end
      default: r.lo = '0;
    endcase
    r.z = (r.lo == 0);
    return r;
  endfunction

  // Issue one op, scramble inputs after accept, measure latency, optionally ack.
  task automatic run_op(input logic [3:0] op, input logic src,
                        input logic [31:0] a, r2, imm, input bit ack,
                        output res_t o, output bit rdy_bad);
    int n;
    rdy_bad = 1'b0;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    alu_ctr = op; alu_src = src;
    read_1 = a; read_2 = r2; imm_ext = imm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_ctr = 4'($urandom_range(15));
    alu_src = 1'($urandom_range(1));
    read_1 = $urandom; read_2 = $urandom; imm_ext = $urandom;
    @(negedge clk);
    n = 1;
    while (n < 100) begin
      if (in_ready) rdy_bad = 1'b1;
      if (out_valid) break;
      @(negedge clk);
      n++;
    end
    o.lo = result; o.hi = result_hi;
    o.z = zero; o.o = ovf; o.e = err;
    o.lat = out_valid ? 8'(n) : 8'hFF;
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({in_ready, out_valid, result, result_hi, zero, ovf, err} !==
        {1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b res=%h hi=%h z=%b o=%b e=%b want 1 0 0 0 1 0 0",
               in_ready, out_valid, result, result_hi, zero, ovf, err);
    end
  endtask

  task automatic test_directed;
    vec_t v[12];
    res_t o;
    bit rb;
    v[0]  = '{OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0,
              '{32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0, 8'd1}};
    v[1]  = '{OP_SUB, 1'b0, 32'd5, 32'd5, 32'd9,
              '{32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd1}};
    v[2]  = '{OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
              '{32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 8'd1}};
    v[3]  = '{OP_SLTU, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1,
              '{32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd1}};
    v[4]  = '{OP_SRA, 1'b0, 32'h8000_0000, 32'd4, 32'd0,
              '{32'hF800_0000, 32'd0, 1'b0, 1'b0, 1'b0, 8'd1}};
    v[5]  = '{OP_SRL, 1'b0, 32'h8000_0000, 32'd4, 32'd0,
              '{32'h0800_0000, 32'd0, 1'b0, 1'b0, 1'b0, 8'd1}};
    v[6]  = '{OP_SRL, 1'b1, 32'h8000_0000, 32'd0, 32'h25,
              '{32'h0400_0000, 32'd0, 1'b0, 1'b0, 1'b0, 8'd1}};
    v[7]  = '{4'b1101, 1'b0, 32'h1234, 32'h5678, 32'd0,
              '{32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd1}};
    v[8]  = '{OP_NOR, 1'b0, 32'hF0F0_0000, 32'h0000_000F, 32'd0,
              '{32'h0F0F_FFF0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd1}};
`ifdef ALU_MULDIV_EN
    v[9]  = '{OP_MULTU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
              '{32'd1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 8'd33}};
    v[10] = '{OP_DIVU, 1'b1, 32'd100, 32'd0, 32'd7,
              '{32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 8'd33}};
    v[11] = '{OP_DIVU, 1'b0, 32'd9, 32'd0, 32'd3,
              '{32'hFFFF_FFFF, 32'd9, 1'b0, 1'b0, 1'b1, 8'd33}};
`else
    v[9]  = '{OP_MULTU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
              '{32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 8'd1}};
    v[10] = '{OP_DIVU, 1'b1, 32'd100, 32'd0, 32'd7,
              '{32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 8'd1}};
    v[11] = '{OP_DIVU, 1'b0, 32'd9, 32'd0, 32'd3,
              '{32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 8'd1}};
`endif
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].src, v[i].a, v[i].r2, v[i].imm, 1'b1, o, rb);
      checks++;
      if ({o, rb} !== {v[i].exp, 1'b0}) begin
        errors++;
        $display("FAIL directed%0d: got %h rdy_bad=%b want %h rdy_bad=0",
                 i, o, rb, v[i].exp);
      end
    end
  endtask

  task automatic test_hold;
    res_t o, want;
    bit rb;
    logic [66:0] snap;
    want = model(OP_DIVU, 1'b0, 32'd9, 32'd0, 32'd0);
    run_op(OP_DIVU, 1'b0, 32'd9, 32'd0, 32'd0, 1'b0, o, rb);
    snap = {want.lo, want.hi, want.z, want.o, want.e};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, result, result_hi, zero, ovf, err} !==
          {1'b1, 1'b0, snap}) begin
        errors++;
        $display("FAIL hold%0d: got vld=%b rdy=%b %h %h %b%b%b want 1 0 %h",
                 i, out_valid, in_ready, result, result_hi, zero, ovf, err, snap);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL hold_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_busy;
    res_t o, want;
    bit rb, seen;
    @(negedge clk);
    alu_ctr = OP_MULTU; alu_src = 1'b0;
    read_1 = 32'h1234_5678; read_2 = 32'h9ABC_DEF0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_output: got out_valid seen=%b want 0", seen);
    end
    want = model(OP_MULTU, 1'b0, 32'h0001_0003, 32'h0002_0005, 32'd0);
    run_op(OP_MULTU, 1'b0, 32'h0001_0003, 32'h0002_0005, 32'd0, 1'b1, o, rb);
    checks++;
    if ({o, rb} !== {want, 1'b0}) begin
      errors++;
      $display("FAIL after_abort: got %h rb=%b want %h", o, rb, want);
    end
  endtask

  task automatic test_random;
    res_t o, want;
    bit rb;
    logic [3:0] op;
    logic src;
    logic [31:0] a, r2, imm;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(15));
      src = 1'($urandom_range(1));
      a = $urandom; r2 = $urandom; imm = $urandom;
      if ($urandom_range(3) == 0) begin
        r2 = 32'($urandom_range(20));
        imm = 32'($urandom_range(20));
      end
      want = model(op, src, a, r2, imm);
      run_op(op, src, a, r2, imm, 1'b1, o, rb);
      checks++;
      if ({o, rb} !== {want, 1'b0}) begin
        errors++;
        $display("FAIL random%0d op=%h src=%b a=%h r2=%h imm=%h: got %h rb=%b want %h",
                 i, op, src, a, r2, imm, o, rb, want);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
